// File: rtl/spi_cmd_sequencer.sv
`timescale 1ns/1ps
// spi_cmd_sequencer: buffers {opcode,arg} command words and sequences an SPI facade with manual CS.
// Define SPISEQ_DELAY_EN to build opcode 0x03 (pause for arg+1 cycles); otherwise 0x03 is invalid.
module spi_cmd_sequencer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        spi_go,
  output logic [7:0]  spi_tx,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        cs_active,
  output logic        idle,
  output logic        err_opcode
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] OP_XFER   = 8'h00;
  localparam logic [7:0] OP_CS_ON  = 8'h01;
  localparam logic [7:0] OP_CS_OFF = 8'h02;
`ifdef SPISEQ_DELAY_EN
  localparam logic [7:0] OP_DELAY  = 8'h03;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
`ifdef SPISEQ_DELAY_EN
    ST_WAIT,
    ST_DELAY
`else
    ST_WAIT
`endif
  } state_t;

  state_t state_q, state_d;

  // ---------------- command FIFO ----------------
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == ST_IDLE) && !empty;

  // NOTE: the storage array carries no reset; emptiness is defined by count alone.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  // NOTE: all registered state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- sequencer ----------------
  logic [15:0] cmd_q;
  logic [7:0]  opcode, arg;
  assign opcode = cmd_q[15:8];
  assign arg    = cmd_q[7:0];

`ifdef SPISEQ_DELAY_EN
  logic [7:0] delay_cnt;
`endif

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    spi_go     = 1'b0;
    err_opcode = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (!empty) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_XFER:             state_d = ST_ISSUE;
          OP_CS_ON, OP_CS_OFF: state_d = ST_IDLE;
`ifdef SPISEQ_DELAY_EN
          OP_DELAY:            state_d = ST_DELAY;
`endif
          default: begin
            err_opcode = 1'b1;
            state_d    = ST_IDLE;
          end
        endcase
      end
      // Holding off while a response is pending guarantees it cannot be overwritten.
      ST_ISSUE: if (!spi_busy && !rsp_valid) begin
        spi_go  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT:  if (spi_done) state_d = ST_IDLE;
`ifdef SPISEQ_DELAY_EN
      ST_DELAY: if (delay_cnt == 8'd0) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      cs_active <= 1'b0;
      spi_tx    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef SPISEQ_DELAY_EN
      delay_cnt <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= mem[rd_ptr];

      // spi_tx is loaded a cycle before go and held until the next data command decodes.
      if (state_q == ST_DECODE) begin
        if (opcode == OP_CS_ON)  cs_active <= 1'b1;
        if (opcode == OP_CS_OFF) cs_active <= 1'b0;
        if (opcode == OP_XFER)   spi_tx    <= arg;
`ifdef SPISEQ_DELAY_EN
        if (opcode == OP_DELAY)  delay_cnt <= arg;
`endif
      end

`ifdef SPISEQ_DELAY_EN
      if (state_q == ST_DELAY && delay_cnt != 8'd0) delay_cnt <= delay_cnt - 8'd1;
`endif

      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (state_q == ST_WAIT && spi_done) begin
        rsp_data  <= spi_rx;
        rsp_valid <= 1'b1;
      end
    end
  end

  assign idle = empty && (state_q == ST_IDLE) && !spi_busy;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for spi_cmd_sequencer: directed timing sequences, a command/effect table,
// and randomized command streams checked against a transaction-level model.
module tb_spi_cmd_sequencer;
  localparam int FIFO_DEPTH = 16;
`ifdef SPISEQ_DELAY_EN
  localparam int DELAY_GO_OFFSET = 10;
  localparam int OP3_ERR         = 0;
`else
  localparam int DELAY_GO_OFFSET = 5;
  localparam int OP3_ERR         = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        spi_go;
  logic [7:0]  spi_tx;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx = '0;
  logic        cs_active, idle, err_opcode;

  spi_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .spi_go(spi_go), .spi_tx(spi_tx), .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx),
    .cs_active(cs_active), .idle(idle), .err_opcode(err_opcode)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [7:0] tx; logic cs; int cyc; } go_rec_t;
  typedef struct { logic [15:0] cmd; logic [7:0] rx; int exp_go; logic [7:0] exp_tx; logic exp_cs; int exp_err; } vec_t;

  go_rec_t     go_q[$];
  logic [7:0]  rx_plan[$];
  logic [7:0]  rx_sent[$];
  logic [7:0]  rsp_got[$];
  logic [15:0] pushed_q[$];
  int          err_seen = 0;
  int          checks = 0;
  int          failures = 0;
  bit          stop_bg = 1'b0;
  int          rsp_mode = 2;  // 0 hold, 1 random, 2 always accept
  int          last_push_cyc = 0;
  logic        model_cs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Starts and ends just after a rising edge.
  task automatic push(input logic [15:0] w);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = w;
    forever begin
      @(negedge clock);
      if (cmd_ready) begin
        pushed_q.push_back(w);
        last_push_cyc = cyc;
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
      n++;
      if (n > 300) begin
        timeout("push");
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clock);
    while (!(idle && !rsp_valid && !spi_done)) begin
      n++;
      if (n > 3000) begin
        timeout(name);
        break;
      end
      @(negedge clock);
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_go(input string name, output int at);
    int n = 0;
    at = -1;
    @(negedge clock);
    while (!spi_go) begin
      n++;
      if (n > 50) begin
        timeout(name);
        break;
      end
      @(negedge clock);
    end
    if (spi_go) at = cyc;
  endtask

  // Facade responder: busy for 1..3 cycles after go, then a one-cycle done with the rx byte.
  task automatic facade();
    go_rec_t    r;
    logic [7:0] rx;
    int         lat;
    while (!stop_bg) begin
      @(negedge clock);
      if (spi_go) begin
        r.tx  = spi_tx;
        r.cs  = cs_active;
        r.cyc = cyc;
        go_q.push_back(r);
        check("go_while_rsp_valid", 32'(rsp_valid), 32'd0);
        lat = $urandom_range(1, 3);
        rx  = (rx_plan.size() > 0) ? rx_plan.pop_front() : 8'($urandom);
        @(posedge clock); #1 spi_busy = 1'b1;
        @(negedge clock);
        check("go_one_cycle", 32'(spi_go), 32'd0);
        repeat (lat) @(posedge clock);
        #1;
        spi_busy = 1'b0;
        spi_done = 1'b1;
        spi_rx   = rx;
        rx_sent.push_back(rx);
        @(negedge clock);
        check("tx_stable_at_done", 32'(spi_tx), 32'(r.tx));
        check("cs_stable_at_done", 32'(cs_active), 32'(r.cs));
        @(posedge clock); #1;
        spi_done = 1'b0;
        spi_rx   = 8'($urandom);
      end
    end
  endtask

  task automatic consumer();
    while (!stop_bg) begin
      @(posedge clock); #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b1;
      endcase
      @(negedge clock);
      if (rsp_valid && rsp_ready) rsp_got.push_back(rsp_data);
    end
  endtask

  task automatic err_monitor();
    while (!stop_bg) begin
      @(negedge clock);
      if (err_opcode) err_seen++;
    end
  endtask

  task automatic clear_obs();
    go_q.delete();
    rx_sent.delete();
    rsp_got.delete();
    pushed_q.delete();
    rx_plan.delete();
    err_seen = 0;
  endtask

  // Replays every accepted command in order and predicts transfers, CS level and errors.
  task automatic model_check(input string name);
    logic [7:0] exp_tx[$];
    logic       exp_cs[$];
    int         exp_err = 0;
    foreach (pushed_q[i]) begin
      case (pushed_q[i][15:8])
        8'h00: begin
          exp_tx.push_back(pushed_q[i][7:0]);
          exp_cs.push_back(model_cs);
        end
        8'h01: model_cs = 1'b1;
        8'h02: model_cs = 1'b0;
`ifdef SPISEQ_DELAY_EN
        8'h03: ;
`endif
        default: exp_err++;
      endcase
    end
    check({name, " go_count"}, go_q.size(), exp_tx.size());
    for (int i = 0; i < go_q.size() && i < exp_tx.size(); i++) begin
      check($sformatf("%s go%0d tx", name, i), 32'(go_q[i].tx), 32'(exp_tx[i]));
      check($sformatf("%s go%0d cs", name, i), 32'(go_q[i].cs), 32'(exp_cs[i]));
    end
    check({name, " err_count"}, err_seen, exp_err);
    check({name, " cs_final"}, 32'(cs_active), 32'(model_cs));
    check({name, " rsp_count"}, rsp_got.size(), rx_sent.size());
    for (int i = 0; i < rsp_got.size() && i < rx_sent.size(); i++)
      check($sformatf("%s rsp%0d", name, i), 32'(rsp_got[i]), 32'(rx_sent[i]));
    clear_obs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   t0, tg, n;
    logic [15:0] w;

    vecs[0]  = '{16'h0100, 8'h00, 0, 8'h00, 1'b1, 0};
    vecs[1]  = '{16'h00A5, 8'h3C, 1, 8'hA5, 1'b1, 0};
    vecs[2]  = '{16'h0200, 8'h00, 0, 8'h00, 1'b0, 0};
    vecs[3]  = '{16'h0755, 8'h00, 0, 8'h00, 1'b0, 1};
    vecs[4]  = '{16'h0101, 8'h00, 0, 8'h00, 1'b1, 0};
    vecs[5]  = '{16'h04AA, 8'h00, 0, 8'h00, 1'b1, 1};
    vecs[6]  = '{16'h00FF, 8'h00, 1, 8'hFF, 1'b1, 0};
    vecs[7]  = '{16'h0300, 8'h00, 0, 8'h00, 1'b1, OP3_ERR};
    vecs[8]  = '{16'h0000, 8'hFF, 1, 8'h00, 1'b1, 0};
    vecs[9]  = '{16'h02FF, 8'h00, 0, 8'h00, 1'b0, 0};
    vecs[10] = '{16'hFF12, 8'h00, 0, 8'h00, 1'b0, 1};
    vecs[11] = '{16'h0001, 8'h81, 1, 8'h01, 1'b0, 0};

    // ---- reset state ----
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst cmd_ready", 32'(cmd_ready), 1);
    check("rst idle", 32'(idle), 1);
    check("rst cs_active", 32'(cs_active), 0);
    check("rst rsp_valid", 32'(rsp_valid), 0);
    check("rst rsp_data", 32'(rsp_data), 0);
    check("rst spi_go", 32'(spi_go), 0);
    check("rst spi_tx", 32'(spi_tx), 0);
    check("rst err_opcode", 32'(err_opcode), 0);
    @(posedge clock); #1;

    // ---- push-to-go and done-to-response latency, response hold ----
    cmd_data  = 16'h00A5;
    cmd_valid = 1'b1;
    @(negedge clock);
    t0 = cyc;
    check("lat push_ready", 32'(cmd_ready), 1);
    @(posedge clock); #1 cmd_valid = 1'b0;
    wait_go("lat go", tg);
    check("lat go_cycle", tg - t0, 3);
    check("lat spi_tx", 32'(spi_tx), 32'hA5);
    @(posedge clock); #1 spi_busy = 1'b1;
    @(negedge clock);
    check("lat go_single", 32'(spi_go), 0);
    check("lat tx_hold", 32'(spi_tx), 32'hA5);
    @(posedge clock); #1;
    spi_busy = 1'b0;
    spi_done = 1'b1;
    spi_rx   = 8'h3C;
    @(negedge clock);
    check("lat rsp_not_early", 32'(rsp_valid), 0);
    @(posedge clock); #1;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    @(negedge clock);
    check("lat rsp_valid", 32'(rsp_valid), 1);
    check("lat rsp_data", 32'(rsp_data), 32'h3C);
    check("lat idle", 32'(idle), 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("lat rsp_held", 32'(rsp_valid), 1);
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(posedge clock); #1 rsp_ready = 1'b0;
    @(negedge clock);
    check("lat rsp_cleared", 32'(rsp_valid), 0);
    @(posedge clock); #1;

    // ---- reset while waiting on a transfer with CS asserted ----
    push(16'h0101);
    push(16'h0033);
    wait_go("rstw go", tg);
    @(posedge clock); #1 spi_busy = 1'b1;
    @(negedge clock);
    check("rstw cs_before", 32'(cs_active), 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    reset    = 1'b0;
    spi_busy = 1'b0;
    @(negedge clock);
    check("rstw cs_active", 32'(cs_active), 0);
    check("rstw rsp_valid", 32'(rsp_valid), 0);
    check("rstw idle", 32'(idle), 1);
    check("rstw cmd_ready", 32'(cmd_ready), 1);
    @(posedge clock); #1;
    spi_done = 1'b1;
    spi_rx   = 8'h77;
    @(posedge clock); #1 spi_done = 1'b0;
    @(negedge clock);
    check("rstw no_rsp", 32'(rsp_valid), 0);
    @(posedge clock); #1;
    clear_obs();
    model_cs = 1'b0;

    fork
      facade();
      consumer();
      err_monitor();
      begin
        // ---- table of single commands and their effects ----
        rsp_mode = 2;
        for (int i = 0; i < 12; i++) begin
          if (vecs[i].exp_go > 0) rx_plan.push_back(vecs[i].rx);
          push(vecs[i].cmd);
          wait_idle($sformatf("vec%0d", i));
          check($sformatf("vec%0d go_count", i), go_q.size(), vecs[i].exp_go);
          if (go_q.size() > 0 && vecs[i].exp_go > 0)
            check($sformatf("vec%0d spi_tx", i), 32'(go_q[0].tx), 32'(vecs[i].exp_tx));
          check($sformatf("vec%0d rsp_count", i), rsp_got.size(), vecs[i].exp_go);
          if (rsp_got.size() > 0 && vecs[i].exp_go > 0)
            check($sformatf("vec%0d rsp_data", i), 32'(rsp_got[0]), 32'(vecs[i].rx));
          check($sformatf("vec%0d cs_active", i), 32'(cs_active), 32'(vecs[i].exp_cs));
          check($sformatf("vec%0d err", i), err_seen, vecs[i].exp_err);
          model_cs = vecs[i].exp_cs;
          clear_obs();
        end

        // ---- CS on, transfer, CS off back-to-back ----
        rx_plan.push_back(8'h3C);
        push(16'h0100);
        push(16'h00A5);
        push(16'h0200);
        wait_idle("cs_seq");
        model_check("cs_seq");

        // ---- opcode 0x03 followed by a transfer ----
        push(16'h0304);
        t0 = last_push_cyc;
        push(16'h0011);
        wait_idle("delay");
        if (go_q.size() > 0) check("delay go_offset", go_q[0].cyc - t0, DELAY_GO_OFFSET);
        model_check("delay");

        // ---- second transfer held off while a response is pending ----
        rsp_mode = 0;
        push(16'h0041);
        push(16'h0042);
        repeat (15) @(posedge clock);
        #1;
        @(negedge clock);
        check("bp go_count", go_q.size(), 1);
        check("bp rsp_valid", 32'(rsp_valid), 1);
        rsp_mode = 2;
        wait_idle("bp");
        model_check("bp");

        // ---- fill the FIFO behind a stalled transfer ----
        rsp_mode = 0;
        push(16'h0011);
        n = 0;
        @(negedge clock);
        while (!rsp_valid && n < 50) begin
          n++;
          @(negedge clock);
        end
        if (!rsp_valid) timeout("full first_rsp");
        @(posedge clock); #1;
        push(16'h0022);
        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (i % 4 == 1)      w = 16'h0101;
          else if (i % 4 == 3) w = 16'h0200;
          else                 w = {8'h00, 8'(8'h40 + i)};
          push(w);
        end
        cmd_data  = 16'h00EE;
        cmd_valid = 1'b1;
        repeat (3) begin
          @(negedge clock);
          check("full cmd_ready", 32'(cmd_ready), 0);
          @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        check("full stall_go_count", go_q.size(), 1);
        rsp_mode = 1;
        wait_idle("full");
        model_check("full");

        // ---- randomized command stream against the model ----
        rsp_mode = 1;
        for (int i = 0; i < 60; i++) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 9: w = {8'h00, 8'($urandom)};
            5:                w = {8'h01, 8'($urandom)};
            6:                w = {8'h02, 8'($urandom)};
            7:                w = {8'h03, 8'($urandom_range(0, 3))};
            default:          w = {8'($urandom_range(4, 255)), 8'($urandom)};
          endcase
          push(w);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
          end
        end
        wait_idle("random");
        model_check("random");

        stop_bg = 1'b1;
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
